systolic_load_sequencer: RTL and testbench

//   Control FSM in front of the 4-parallel Q8.24 systolic core.
//   - Latches the opcode on start_in.
//   - Steers the UART byte stream into the A operand buffer (A_BYTES bytes), then the B buffer (B_BYTES bytes).
//   - Fires the core, waits for its completion, and reports busy/done/error to the pins.
//   - Sits between the UART receiver and the operand buffers / core start logic.

---
 rtl/systolic_load_sequencer.sv | 149 ++++++++++++++
 tb/tb_systolic_load_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_load_sequencer.sv
// Load/run sequencer for the systolic core: steers UART bytes into the A then B operand
// buffers, fires the core, waits for completion and reports busy/done/error.
module systolic_load_sequencer #(
  parameter int A_BYTES     = 36,
  parameter int B_BYTES     = 36,
  parameter int GAP_TIMEOUT = 4000,
  parameter int OPCODE_W    = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_in,
  input  logic [OPCODE_W-1:0] opcode_in,
  input  logic                rx_valid_in,
  input  logic [7:0]          rx_data_in,
  input  logic                rx_err_in,
  input  logic                core_done_in,
  output logic                buf_we_out,
  output logic                buf_sel_out,
  output logic [5:0]          buf_addr_out,
  output logic [7:0]          buf_data_out,
  output logic                core_start_out,
  output logic [OPCODE_W-1:0] core_opcode_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                error_out
);

  localparam int CNT_W = 7;
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_BYTES - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(B_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_RUN,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                buf_we_q, buf_we_d;
  logic                buf_sel_q, buf_sel_d;
  logic [5:0]          buf_addr_q, buf_addr_d;
  logic [7:0]          buf_data_q, buf_data_d;
  logic                core_start_q, core_start_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      opcode_q     <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      buf_we_q     <= 1'b0;
      buf_sel_q    <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      buf_we_q     <= buf_we_d;
      buf_sel_q    <= buf_sel_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      core_start_q <= core_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    buf_we_d     = 1'b0;
    buf_sel_d    = buf_sel_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    core_start_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_in) begin
          state_d  = S_LOAD_A;
          opcode_d = opcode_in;
          cnt_d    = '0;
          gap_d    = '0;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        // A framing error beats a byte arriving in the same cycle.
        if (rx_err_in) begin
          state_d = S_ERROR;
        end else if (rx_valid_in) begin
          buf_we_d   = 1'b1;
          buf_sel_d  = (state_q == S_LOAD_B);
          buf_addr_d = cnt_q[5:0];
          buf_data_d = rx_data_in;
          gap_d      = '0;
          if (state_q == S_LOAD_A && cnt_q == A_LAST) begin
            state_d = S_LOAD_B;
            cnt_d   = '0;
          end else if (state_q == S_LOAD_B && cnt_q == B_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
          if (gap_d == GAP_LIMIT) begin
            state_d = S_ERROR;
          end
        end
      end
      S_RUN: begin
        core_start_d = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // The cycle carrying the start pulse still sees the previous run's done level.
        if (core_done_in && !core_start_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign buf_we_out      = buf_we_q;
  assign buf_sel_out     = buf_sel_q;
  assign buf_addr_out    = buf_addr_q;
  assign buf_data_out    = buf_data_q;
  assign core_start_out  = core_start_q;
  assign core_opcode_out = opcode_q;
  assign busy_out        = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                           (state_q == S_RUN)    || (state_q == S_WAIT);
  assign done_out        = (state_q == S_DONE);
  assign error_out       = (state_q == S_ERROR);

endmodule

// File: tb/tb_systolic_load_sequencer.sv
// Randomized bench for systolic_load_sequencer: expected buffer writes are built as a list
// of (buffer, address, byte) from the bytes sent and compared with the observed writes.
module tb_systolic_load_sequencer;
  localparam int A_BYTES     = 36;
  localparam int B_BYTES     = 36;
  localparam int GAP_TIMEOUT = 4000;
  localparam int OPCODE_W    = 4;

  logic                clk_in = 1'b0;
  logic                rst_n_in;
  logic                start_in;
  logic [OPCODE_W-1:0] opcode_in;
  logic                rx_valid_in;
  logic [7:0]          rx_data_in;
  logic                rx_err_in;
  logic                core_done_in;
  logic                buf_we_out;
  logic                buf_sel_out;
  logic [5:0]          buf_addr_out;
  logic [7:0]          buf_data_out;
  logic                core_start_out;
  logic [OPCODE_W-1:0] core_opcode_out;
  logic                busy_out;
  logic                done_out;
  logic                error_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [14:0] wr_q[$];
  int          wr_cyc_q[$];
  int          start_cyc_q[$];

  systolic_load_sequencer #(
    .A_BYTES(A_BYTES), .B_BYTES(B_BYTES), .GAP_TIMEOUT(GAP_TIMEOUT), .OPCODE_W(OPCODE_W)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .opcode_in(opcode_in),
    .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in), .rx_err_in(rx_err_in),
    .core_done_in(core_done_in), .buf_we_out(buf_we_out), .buf_sel_out(buf_sel_out),
    .buf_addr_out(buf_addr_out), .buf_data_out(buf_data_out), .core_start_out(core_start_out),
    .core_opcode_out(core_opcode_out), .busy_out(busy_out), .done_out(done_out),
    .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (buf_we_out) begin
      wr_q.push_back({buf_sel_out, buf_addr_out, buf_data_out});
      wr_cyc_q.push_back(cyc);
    end
    if (core_start_out) start_cyc_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc_q.delete();
    start_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d);
    repeat ($urandom_range(0, 2)) tick();
    rx_valid_in = 1'b1;
    rx_data_in  = d;
    tick();
    rx_valid_in = 1'b0;
    rx_data_in  = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; start_in = 1'b0; opcode_in = '0; rx_valid_in = 1'b0;
    rx_data_in = '0; rx_err_in = 1'b0; core_done_in = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({buf_we_out, buf_sel_out, buf_addr_out, buf_data_out, core_start_out,
         core_opcode_out, busy_out, done_out, error_out} !== 24'h0)
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b err=%b we=%b op=%h, expected all 0",
               busy_out, done_out, error_out, buf_we_out, core_opcode_out);
    else n_pass++;
    rst_n_in = 1'b1;
    tick();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      rx_valid_in = 1'b1; rx_data_in = 8'($urandom);
      tick();
      rx_valid_in = 1'b0;
    end
    tick();
    n_checks++;
    if (wr_q.size() !== 0 || busy_out !== 1'b0)
      $display("[TB] FAIL idle_drop: got %0d writes busy=%b, expected 0 writes busy=0", wr_q.size(), busy_out);
    else n_pass++;
  endtask

  task automatic run_load(input logic [OPCODE_W-1:0] op, input bit inject_start,
                          input bit dual_start, output int start_cyc);
    logic [14:0] exp_q[$];
    logic [7:0]  d;
    int          busy_low = 0;
    int          mism = 0;
    int          first_bad = -1;
    int          n = 0;
    start_cyc = -1;
    clear_log();
    start_in = 1'b1; opcode_in = op;
    if (dual_start) begin rx_valid_in = 1'b1; rx_data_in = 8'hEE; end
    tick();
    start_in = 1'b0; rx_valid_in = 1'b0; opcode_in = ~op;
    n_checks++;
    if (busy_out !== 1'b1 || done_out !== 1'b0 || error_out !== 1'b0 || core_opcode_out !== op)
      $display("[TB] FAIL start_accept: got busy=%b done=%b err=%b op=%h, expected 1 0 0 op=%h",
               busy_out, done_out, error_out, core_opcode_out, op);
    else n_pass++;
    for (int k = 0; k < A_BYTES + B_BYTES; k++) begin
      d = 8'($urandom);
      if (k < A_BYTES) exp_q.push_back({1'b0, 6'(k), d});
      else             exp_q.push_back({1'b1, 6'(k - A_BYTES), d});
    end
    for (int k = 0; k < A_BYTES + B_BYTES; k++) begin
      if (inject_start && k == A_BYTES + 10) begin
        start_in = 1'b1; opcode_in = ~op;
        tick();
        start_in = 1'b0;
      end
      send_byte(exp_q[k][7:0]);
      if (!busy_out) busy_low++;
    end
    while (start_cyc_q.size() == 0 && n < 10) begin
      tick();
      n++;
      if (!busy_out) busy_low++;
    end
    tick();
    core_done_in = 1'b0;
    repeat (2) tick();
    if (!busy_out) busy_low++;
    n_checks++;
    if (busy_low !== 0) $display("[TB] FAIL busy_during_load: got %0d low samples, expected 0", busy_low);
    else n_pass++;
    n_checks++;
    if (wr_q.size() !== A_BYTES + B_BYTES)
      $display("[TB] FAIL write_count: got %0d, expected %0d", wr_q.size(), A_BYTES + B_BYTES);
    else n_pass++;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    n_checks++;
    if (mism !== 0)
      $display("[TB] FAIL write_contents: %0d bad, first #%0d got %h expected %h (sel,addr,data)",
               mism, first_bad, wr_q[first_bad], exp_q[first_bad]);
    else n_pass++;
    n_checks++;
    if (start_cyc_q.size() !== 1)
      $display("[TB] FAIL start_pulse_count: got %0d, expected 1", start_cyc_q.size());
    else n_pass++;
    if (start_cyc_q.size() > 0 && wr_cyc_q.size() > 0) begin
      start_cyc = start_cyc_q[0];
      n_checks++;
      if (start_cyc !== wr_cyc_q[wr_cyc_q.size() - 1] + 1)
        $display("[TB] FAIL start_timing: got cycle %0d, expected %0d",
                 start_cyc, wr_cyc_q[wr_cyc_q.size() - 1] + 1);
      else n_pass++;
    end
    n_checks++;
    if (core_opcode_out !== op || done_out !== 1'b0 || busy_out !== 1'b1)
      $display("[TB] FAIL wait_state: got op=%h done=%b busy=%b, expected op=%h done=0 busy=1",
               core_opcode_out, done_out, busy_out, op);
    else n_pass++;
  endtask

  task automatic test_full_load(output int start_cyc);
    run_load(4'h1, 1'b1, 1'b1, start_cyc);
  endtask

  task automatic test_done(input int start_cyc);
    int n = 0;
    while (cyc < start_cyc + 20 && n < 100) begin tick(); n++; end
    start_in = 1'b1; opcode_in = 4'hF;
    tick();
    start_in = 1'b0;
    tick();
    n_checks++;
    if (busy_out !== 1'b1 || core_opcode_out !== 4'h1 || done_out !== 1'b0)
      $display("[TB] FAIL start_ignored_wait: got busy=%b op=%h done=%b, expected 1 1 0",
               busy_out, core_opcode_out, done_out);
    else n_pass++;
    n = 0;
    while (cyc < start_cyc + 50 && n < 100) begin tick(); n++; end
    core_done_in = 1'b1;
    tick();
    n_checks++;
    if (done_out !== 1'b1 || busy_out !== 1'b0)
      $display("[TB] FAIL done_rise: got done=%b busy=%b, expected done=1 busy=0", done_out, busy_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int sc;
    run_load(4'h3, 1'b0, 1'b0, sc);
    core_done_in = 1'b1;
    tick();
    core_done_in = 1'b0;
    n_checks++;
    if (done_out !== 1'b1 || core_opcode_out !== 4'h3)
      $display("[TB] FAIL second_done: got done=%b op=%h, expected done=1 op=3", done_out, core_opcode_out);
    else n_pass++;
  endtask

  task automatic test_gap_timeout();
    int n = 0;
    int err_cyc;
    clear_log();
    start_in = 1'b1; opcode_in = 4'($urandom);
    tick();
    start_in = 1'b0;
    for (int k = 0; k < 10; k++) send_byte(8'($urandom));
    while (!error_out && n < GAP_TIMEOUT + 50) begin tick(); n++; end
    err_cyc = cyc;
    n_checks++;
    if (error_out !== 1'b1) $display("[TB] FAIL gap_error: got error=%b, expected 1", error_out);
    else n_pass++;
    n_checks++;
    if (wr_q.size() !== 10 || start_cyc_q.size() !== 0)
      $display("[TB] FAIL gap_writes: got %0d writes %0d starts, expected 10 0", wr_q.size(), start_cyc_q.size());
    else n_pass++;
    if (wr_cyc_q.size() >= 10) begin
      n_checks++;
      if (err_cyc - wr_cyc_q[9] !== GAP_TIMEOUT)
        $display("[TB] FAIL gap_timing: got %0d cycles, expected %0d", err_cyc - wr_cyc_q[9], GAP_TIMEOUT);
      else n_pass++;
    end
  endtask

  task automatic test_rx_err();
    clear_log();
    start_in = 1'b1; opcode_in = 4'h5;
    tick();
    start_in = 1'b0;
    n_checks++;
    if (error_out !== 1'b0 || busy_out !== 1'b1)
      $display("[TB] FAIL error_clear: got error=%b busy=%b, expected 0 1", error_out, busy_out);
    else n_pass++;
    for (int k = 0; k < A_BYTES + 5; k++) send_byte(8'($urandom));
    rx_valid_in = 1'b1; rx_err_in = 1'b1; rx_data_in = 8'h5A;
    tick();
    rx_valid_in = 1'b0; rx_err_in = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (error_out !== 1'b1 || busy_out !== 1'b0)
      $display("[TB] FAIL rx_err_state: got error=%b busy=%b, expected 1 0", error_out, busy_out);
    else n_pass++;
    n_checks++;
    if (wr_q.size() !== A_BYTES + 5 || start_cyc_q.size() !== 0)
      $display("[TB] FAIL rx_err_writes: got %0d writes %0d starts, expected %0d 0",
               wr_q.size(), start_cyc_q.size(), A_BYTES + 5);
    else n_pass++;
    if (wr_q.size() > 0) begin
      n_checks++;
      if (wr_q[wr_q.size() - 1][14:8] !== {1'b1, 6'd4})
        $display("[TB] FAIL rx_err_last_addr: got %h, expected %h", wr_q[wr_q.size() - 1][14:8], {1'b1, 6'd4});
      else n_pass++;
    end
  endtask

  task automatic test_reset_midload();
    int sc;
    clear_log();
    start_in = 1'b1; opcode_in = 4'h9;
    tick();
    start_in = 1'b0;
    for (int k = 0; k < 19; k++) send_byte(8'($urandom) | 8'h01);
    rx_valid_in = 1'b1; rx_data_in = 8'hC3;
    #2;
    rst_n_in = 1'b0;
    #1;
    n_checks++;
    if ({buf_we_out, buf_sel_out, buf_addr_out, buf_data_out, core_start_out,
         core_opcode_out, busy_out, done_out, error_out} !== 24'h0)
      $display("[TB] FAIL async_reset: got busy=%b we=%b data=%h op=%h, expected all 0",
               busy_out, buf_we_out, buf_data_out, core_opcode_out);
    else n_pass++;
    clear_log();
    repeat (3) tick();
    rx_valid_in = 1'b0;
    n_checks++;
    if (wr_q.size() !== 0 || busy_out !== 1'b0)
      $display("[TB] FAIL reset_hold: got %0d writes busy=%b, expected 0 0", wr_q.size(), busy_out);
    else n_pass++;
    rst_n_in = 1'b1;
    tick();
    run_load(4'($urandom), 1'b0, 1'b0, sc);
  endtask

  initial begin
    int sc;
    $display("[TB] starting systolic_load_sequencer bench");
    test_reset();
    test_full_load(sc);
    test_done(sc);
    test_back_to_back();
    test_gap_timeout();
    test_rx_err();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
